// File: rtl/ex_branch_stage.sv
// Execute-stage back end: resolves branches and jumps from ALU flags, pulses a PC redirect
// and registers results into a 2-entry skid buffer. Optional feature macro: MISALIGN_TRAP_EN.
module ex_branch_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_negative,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic         op_branch,
  input  logic         op_jal,
  input  logic         op_jalr,
  input  logic [2:0]   funct3,
  input  logic [4:0]   rd,
  input  logic         reg_write,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [4:0]   out_rd,
  output logic         out_reg_write,
  output logic         redirect_valid,
  output logic [N-1:0] redirect_pc,
  output logic         misalign_trap
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is registered and equals ~skid_valid; out_valid is the main entry's valid bit.
  typedef struct packed {
    logic [N-1:0] result;
    logic [4:0]   rd;
    logic         reg_write;
  } entry_t;

  entry_t       main_q, main_d, skid_q, skid_d, new_entry;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         redir_valid_q, redir_valid_d;
  logic [N-1:0] redir_pc_q, redir_pc_d;
  logic         trap_q, trap_d;

  logic         cond_met, taken, misaligned, accept, drain, is_jump;
  logic [N-1:0] pc_plus_imm, pc_plus_4, target;

  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      3'b000:  cond_met = alu_zero;
      3'b001:  cond_met = ~alu_zero;
      3'b100:  cond_met = alu_negative ^ alu_overflow;
      3'b101:  cond_met = ~(alu_negative ^ alu_overflow);
      3'b110:  cond_met = ~alu_carry;
      3'b111:  cond_met = alu_carry;
      default: cond_met = 1'b0;
    endcase
  end

  assign is_jump     = op_jal | op_jalr;
  assign taken       = is_jump | (op_branch & cond_met);
  assign pc_plus_imm = pc + imm;
  assign pc_plus_4   = pc + N'(4);
  assign target      = op_jalr ? {alu_out[N-1:1], 1'b0} : pc_plus_imm;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = taken & (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign new_entry.result    = is_jump ? pc_plus_4 : alu_out;
  assign new_entry.rd        = rd;
  assign new_entry.reg_write = reg_write & ~op_branch & (rd != 5'd0) & ~misaligned;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;

  // Accept only happens with skid empty, so a draining main either refills from the
  // incoming op or from skid, never both.
  always_comb begin
    main_d        = main_q;
    main_valid_d  = main_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    trap_d        = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!main_valid_q || drain) begin
          main_d       = new_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = new_entry;
          skid_valid_d = 1'b1;
        end
        redir_valid_d = taken & ~misaligned;
        trap_d        = misaligned;
        if (taken) redir_pc_d = target;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      trap_q        <= 1'b0;
    end else begin
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      trap_q        <= trap_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign misalign_trap  = trap_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Bench for ex_branch_stage: directed scenarios plus randomized traffic checked against a
// 2-deep FIFO reference model whose branch outcomes come from comparing the source operands.
module tb_ex_branch_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_ready;
  logic [63:0] alu_out, pc, imm, out_result, redirect_pc;
  logic        alu_zero, alu_negative, alu_carry, alu_overflow;
  logic        op_branch, op_jal, op_jalr, reg_write;
  logic [2:0]  funct3;
  logic [4:0]  rd, out_rd;
  logic        out_valid, out_reg_write, redirect_valid, misalign_trap;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [69:0] exp_q[$];   // {result, rd, reg_write}, head = entry on the outputs
  logic        exp_redir = 1'b0, exp_trap = 1'b0;
  logic [63:0] exp_rpc = '0;
  logic        drv_cond = 1'b0;

  ex_branch_stage #(.N(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .pc(pc), .imm(imm),
    .op_branch(op_branch), .op_jal(op_jal), .op_jalr(op_jalr), .funct3(funct3),
    .rd(rd), .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  function automatic logic flag_taken(input logic [2:0] f3, input logic z, n, c, v);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic cmp_taken(input logic [2:0] f3, input logic [63:0] a, b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    in_valid = 0; flush = 0; op_branch = 0; op_jal = 0; op_jalr = 0; funct3 = 0;
    alu_zero = 0; alu_negative = 0; alu_carry = 0; alu_overflow = 0;
    alu_out = 0; pc = 0; imm = 0; rd = 0; reg_write = 0; drv_cond = 0;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] p, input logic [63:0] i,
                       input logic [3:0] zncv, input logic [4:0] d, input logic w);
    in_valid = 1; op_branch = br; op_jal = jal; op_jalr = jalr; funct3 = f3;
    alu_out = a; pc = p; imm = i;
    {alu_zero, alu_negative, alu_carry, alu_overflow} = zncv;
    rd = d; reg_write = w;
    drv_cond = flag_taken(f3, zncv[3], zncv[2], zncv[1], zncv[0]);
  endtask

  // Advance one clock; the model consumes the inputs the bench is driving.
  task automatic tick();
    logic acc, drn, tk, mis, wr;
    logic [63:0] tgt, res;
    acc = in_valid && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && out_ready;
    tk  = op_jal || op_jalr || (op_branch && drv_cond);
    tgt = op_jalr ? (alu_out & ~64'd1) : pc + imm;
`ifdef MISALIGN_TRAP_EN
    mis = tk && (tgt % 4 != 0);
`else
    mis = 1'b0;
`endif
    res = (op_jal || op_jalr) ? pc + 64'd4 : alu_out;
    wr  = reg_write && !op_branch && (rd != 0) && !mis;
    if (flush) begin
      exp_q.delete();
      exp_redir = 0;
      exp_trap  = 0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({res, rd, wr});
      exp_redir = acc && tk && !mis;
      exp_trap  = acc && mis;
      if (acc && tk) exp_rpc = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_redirect_valid: got %b expected 0", redirect_valid); end
    n_vec++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL rst_trap: got %b expected 0", misalign_trap); end
    n_vec++; if (out_result !== 64'h0) begin n_err++; $display("FAIL rst_out_result: got %h expected 0", out_result); end
    n_vec++; if (redirect_pc !== 64'h0) begin n_err++; $display("FAIL rst_redirect_pc: got %h expected 0", redirect_pc); end
    n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL rst_out_rd: got %h expected 0", out_rd); end
    n_vec++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_out_reg_write: got %b expected 0", out_reg_write); end
  endtask

  task automatic test_beq();
    out_ready = 1;
    drive(1, 0, 0, 3'b000, 64'h0, 64'h100, 64'h20, 4'b1010, 5'd3, 1'b1);
    tick();
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_taken_pulse: got %b expected 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h120) begin n_err++; $display("FAIL beq_target: got %h expected 120", redirect_pc); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_out_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL beq_no_write: got %b expected 0", out_reg_write); end
    idle();
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_pulse_width: got %b expected 0", redirect_valid); end
    drive(1, 0, 0, 3'b000, 64'h5, 64'h100, 64'h20, 4'b0010, 5'd3, 1'b1);
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_not_taken: got %b expected 0", redirect_valid); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_nt_out_valid: got %b expected 1", out_valid); end
    idle();
    tick();
  endtask

  task automatic test_conditions();
    // {funct3, Z N C V, expected taken}
    logic [7:0] tbl[6];
    tbl[0] = {3'b110, 4'b0000, 1'b1};   // BLTU, C=0
    tbl[1] = {3'b101, 4'b0101, 1'b1};   // BGE, N=V=1
    tbl[2] = {3'b100, 4'b0101, 1'b0};   // BLT, N=V=1
    tbl[3] = {3'b111, 4'b0010, 1'b1};   // BGEU, C=1
    tbl[4] = {3'b010, 4'b1111, 1'b0};   // reserved
    tbl[5] = {3'b001, 4'b1000, 1'b0};   // BNE, Z=1
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] e;
      e = tbl[k];
      drive(1, 0, 0, e[7:5], 64'h1, 64'h200 + 64'(k * 16), 64'h40, e[4:1], 5'd7, 1'b1);
      tick();
      n_vec++; if (redirect_valid !== e[0]) begin n_err++; $display("FAIL cond_%0d_pulse: got %b expected %b", k, redirect_valid, e[0]); end
      if (e[0]) begin
        n_vec++; if (redirect_pc !== 64'h240 + 64'(k * 16)) begin n_err++; $display("FAIL cond_%0d_target: got %h expected %h", k, redirect_pc, 64'h240 + 64'(k * 16)); end
      end
      idle();
      tick();
      n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL cond_%0d_clear: got %b expected 0", k, redirect_valid); end
    end
  endtask

  task automatic test_jumps();
    out_ready = 1;
    drive(0, 0, 1, 3'b000, 64'h2005, 64'h40, 64'h0, 4'b0000, 5'd1, 1'b1);
    tick();
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jalr_pulse: got %b expected 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h2004) begin n_err++; $display("FAIL jalr_target: got %h expected 2004", redirect_pc); end
    n_vec++; if (out_result !== 64'h44) begin n_err++; $display("FAIL jalr_link: got %h expected 44", out_result); end
    n_vec++; if (out_rd !== 5'd1) begin n_err++; $display("FAIL jalr_rd: got %h expected 1", out_rd); end
    n_vec++; if (out_reg_write !== 1'b1) begin n_err++; $display("FAIL jalr_write: got %b expected 1", out_reg_write); end
    drive(0, 1, 0, 3'b000, 64'h0, 64'h80, 64'h100, 4'b0000, 5'd0, 1'b1);
    tick();
    n_vec++; if (redirect_pc !== 64'h180) begin n_err++; $display("FAIL jal_target: got %h expected 180", redirect_pc); end
    n_vec++; if (out_result !== 64'h84) begin n_err++; $display("FAIL jal_link: got %h expected 84", out_result); end
    n_vec++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL jal_rd0_write: got %b expected 0", out_reg_write); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 3'b000, 64'hA000 + 64'(k), 64'h0, 64'h0, 4'b0000, 5'(k + 2), 1'b1);
      tick();
      n_vec++; if (out_result !== 64'hA000 + 64'(k)) begin n_err++; $display("FAIL b2b_%0d_result: got %h expected %h", k, out_result, 64'hA000 + 64'(k)); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_%0d_in_ready: got %b expected 1", k, in_ready); end
    end
    idle();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(0, 0, 0, 3'b000, 64'hAA, 64'h0, 64'h0, 4'b0000, 5'd4, 1'b1);
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
    drive(0, 0, 0, 3'b000, 64'hBB, 64'h0, 64'h0, 4'b0000, 5'd5, 1'b1);
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
    drive(0, 0, 0, 3'b000, 64'hCC, 64'h0, 64'h0, 4'b0000, 5'd6, 1'b1);
    tick();
    n_vec++; if (out_result !== 64'hAA) begin n_err++; $display("FAIL bp_hold_head: got %h expected AA", out_result); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
    out_ready = 1;
    tick();
    n_vec++; if (out_result !== 64'hBB) begin n_err++; $display("FAIL bp_second: got %h expected BB", out_result); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
    tick();
    n_vec++; if (out_result !== 64'hCC) begin n_err++; $display("FAIL bp_third: got %h expected CC", out_result); end
    n_vec++; if (out_rd !== 5'd6) begin n_err++; $display("FAIL bp_third_rd: got %h expected 6", out_rd); end
    idle();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(0, 0, 0, 3'b000, 64'h11, 64'h0, 64'h0, 4'b0000, 5'd8, 1'b1);
    tick();
    drive(0, 0, 0, 3'b000, 64'h22, 64'h0, 64'h0, 4'b0000, 5'd9, 1'b1);
    tick();
    drive(0, 1, 0, 3'b000, 64'h0, 64'h300, 64'h40, 4'b0000, 5'd1, 1'b1);
    flush = 1;
    out_ready = 1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_redirect: got %b expected 0", redirect_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    idle();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stays_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_misalign();
    out_ready = 1;
    drive(0, 1, 0, 3'b000, 64'h0, 64'h100, 64'h6, 4'b0000, 5'd2, 1'b1);
    tick();
`ifdef MISALIGN_TRAP_EN
    n_vec++; if (misalign_trap !== 1'b1) begin n_err++; $display("FAIL mis_trap: got %b expected 1", misalign_trap); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_redirect: got %b expected 0", redirect_valid); end
    n_vec++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL mis_no_write: got %b expected 0", out_reg_write); end
`else
    n_vec++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL mis_trap_tied: got %b expected 0", misalign_trap); end
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL mis_redirect: got %b expected 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h106) begin n_err++; $display("FAIL mis_target: got %h expected 106", redirect_pc); end
`endif
    idle();
    tick();
    n_vec++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL mis_pulse_width: got %b expected 0", misalign_trap); end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    drive(0, 0, 0, 3'b000, 64'h77, 64'h0, 64'h0, 4'b0000, 5'd3, 1'b1);
    tick();
    drive(0, 1, 0, 3'b000, 64'h0, 64'h500, 64'h20, 4'b0000, 5'd3, 1'b1);
    tick();
    idle();
    #2 rst = 1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL arst_redirect: got %b expected 0", redirect_valid); end
    n_vec++; if (out_result !== 64'h0) begin n_err++; $display("FAIL arst_result: got %h expected 0", out_result); end
    rst = 0;
    exp_q.delete();
    exp_redir = 0;
    exp_trap = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [63:0] rs1, rs2, diff;
      logic [69:0] head;
      int kind;
      rs1 = {$urandom, $urandom};
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : {$urandom, $urandom};
      diff = rs1 - rs2;
      alu_zero     = (diff == 0);
      alu_negative = diff[63];
      alu_carry    = (rs1 >= rs2);
      alu_overflow = (rs1[63] != rs2[63]) && (diff[63] != rs1[63]);
      kind = $urandom_range(0, 9);
      op_branch = (kind < 4);
      op_jal    = (kind == 4);
      op_jalr   = (kind == 5);
      funct3    = 3'($urandom_range(0, 7));
      alu_out   = (kind < 4) ? diff : {$urandom, $urandom};
      pc        = {$urandom, $urandom} & ~64'h3;
      imm       = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) imm = imm & ~64'h3;
      rd        = 5'($urandom_range(0, 31));
      reg_write = 1'($urandom_range(0, 1));
      drv_cond  = cmp_taken(funct3, rs1, rs2);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
      n_vec++; if (out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_%0d_out_valid: got %b expected %b", cyc, out_valid, exp_q.size() > 0); end
      n_vec++; if (in_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL rnd_%0d_in_ready: got %b expected %b", cyc, in_ready, exp_q.size() < 2); end
      n_vec++; if (redirect_valid !== exp_redir) begin n_err++; $display("FAIL rnd_%0d_redirect: got %b expected %b", cyc, redirect_valid, exp_redir); end
      n_vec++; if (misalign_trap !== exp_trap) begin n_err++; $display("FAIL rnd_%0d_trap: got %b expected %b", cyc, misalign_trap, exp_trap); end
      if (exp_redir) begin
        n_vec++; if (redirect_pc !== exp_rpc) begin n_err++; $display("FAIL rnd_%0d_target: got %h expected %h", cyc, redirect_pc, exp_rpc); end
      end
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        n_vec++; if ({out_result, out_rd, out_reg_write} !== head) begin n_err++; $display("FAIL rnd_%0d_entry: got %h/%h/%b expected %h/%h/%b", cyc, out_result, out_rd, out_reg_write, head[69:6], head[5:1], head[0]); end
      end
    end
    idle();
    out_ready = 1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    idle();
    out_ready = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_beq();
    test_conditions();
    test_jumps();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_misalign();
    test_async_reset();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
